mod_mac_pipe: RTL and testbench
===============================

MOD_MAC_PIPE -- requirements
Module: mod_mac_pipe

Interface
REQ-001 SHALL have parameter MODULUS, default 177147, the residue modulus (digit modulus), legal range 2 to 2^DATA_WIDTH-1.
REQ-002 SHALL have parameter DATA_WIDTH, default 18, the operand and result width in bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, marks op_a/op_b/op_c/acc_en/acc_clr as a valid item this cycle.
REQ-006 SHALL have port op_a, input, DATA_WIDTH, the multiplicand, required to be < MODULUS.
REQ-007 SHALL have port op_b, input, DATA_WIDTH, the multiplier, required to be < MODULUS.
REQ-008 SHALL have port op_c, input, DATA_WIDTH, the addend, required to be < MODULUS.
REQ-009 SHALL have port acc_en, input, 1, item adds into and updates the running accumulator.
REQ-010 SHALL have port acc_clr, input, 1, treats the accumulator as 0 before this item; honoured only with in_valid=1.
REQ-011 SHALL have port out_valid, output, 1, result carries a completed item this cycle.
REQ-012 SHALL have port result, output, DATA_WIDTH, the modular result.
REQ-013 SHALL have port range_err, output, 1, sticky operand-range error flag (see Configuration).

Function
REQ-014 SHALL have fixed latency 4: an item accepted at edge t SHALL appear with out_valid=1 after edge t+4; 1 item/cycle sustained, no stalls.
REQ-015 With acc_en=0, result SHALL be (op_a*op_b + op_c) mod MODULUS; the accumulator SHALL be unchanged.
REQ-016 With acc_en=1, result SHALL be (op_a*op_b + op_c + A) mod MODULUS, where A = 0 if acc_clr=1 else the accumulator; the accumulator SHALL load result on the same edge.
REQ-017 acc_clr with acc_en=0 SHALL zero the accumulator when the item reaches stage 4; result SHALL follow REQ-015.
REQ-018 acc_en/acc_clr SHALL travel with their item; the accumulator add SHALL occur only in stage 4, so back-to-back accumulate items chain without hazard.
REQ-019 Product SHALL be computed at full 2*DATA_WIDTH width and reduced by Barrett reduction with at most two conditional subtractions; the final add SHALL use one conditional subtraction; no intermediate truncation.
REQ-020 Bubbles (in_valid=0) SHALL propagate: out_valid=0 and result holds its last value.
REQ-021 Behaviour for operands >= MODULUS is undefined unless MOD_MAC_RANGE_CHECK_EN is defined.

Reset
REQ-022 Reset SHALL clear all pipeline valid bits, the accumulator, result, and range_err to 0; out_valid=0 the cycle after reset.
REQ-023 Items in flight at reset SHALL be discarded and never produce out_valid.
REQ-024 in_valid coincident with reset SHALL be ignored; reset wins.

Configuration
REQ-025 With MOD_MAC_RANGE_CHECK_EN defined, any accepted item with op_a, op_b or op_c >= MODULUS SHALL set range_err, which stays 1 until reset; the item is still processed.
REQ-026 Without MOD_MAC_RANGE_CHECK_EN, range_err SHALL be tied 0 and no compare logic SHALL be built; the port list is identical either way.

Structure
REQ-027 Package mod_mac_pkg SHALL hold the LATENCY constant (4) and a constant function computing the Barrett factor floor(2^(2*DATA_WIDTH)/MODULUS).
REQ-028 Reduction SHALL live in sub-module mod_barrett_reduce (2 pipeline stages, parameters MODULUS, DATA_WIDTH), instantiated once.

Verification (MODULUS=177147, DATA_WIDTH=18)
REQ-029 op_a=119687, op_b=74565, op_c=0, acc_en=0 -> result 149589 exactly 4 cycles later.
REQ-030 op_a=op_b=177146, op_c=0 -> 1; same with op_c=177146 -> 0 (wrap boundary).
REQ-031 Back-to-back acc_en=1, op_b=1, op_c=0, op_a=1,2,3,4, acc_clr on first -> results 1,3,6,10 on 4 consecutive cycles.
REQ-032 acc_clr+acc_en, op_a=177146, op_b=1, then same without clr -> 177146, 177145 (accumulator wrap).
REQ-033 Reset asserted 2 cycles after 3 accepted items -> no out_valid for any of them; accumulator 0; next item op_a=5, op_b=7, op_c=0 -> 35.
REQ-034 With MOD_MAC_RANGE_CHECK_EN: op_a=177147 -> range_err=1 and held through later legal items until reset; without the macro range_err stays 0.

Source files
------------

// File: rtl/mod_mac_pkg.sv
// rtl/mod_mac_pkg.sv - shared constants and Barrett factor helper for the modular MAC pipe
package mod_mac_pkg;

  // Edges from input capture to result for one item, counted after the accepting edge.
  localparam int LATENCY = 4;

  // Widest product the helper supports (2*DATA_WIDTH must not exceed this).
  localparam int FACT_W = 128;

  // floor(2^(2*data_width) / modulus), evaluated at elaboration time.
  function automatic logic [FACT_W-1:0] barrett_factor(input int modulus, input int data_width);
    logic [FACT_W-1:0] num;
    logic [FACT_W-1:0] den;
    num = FACT_W'(1) << (2 * data_width);
    den = FACT_W'(modulus);
    return num / den;
  endfunction

endpackage

// File: rtl/mod_barrett_reduce.sv
// rtl/mod_barrett_reduce.sv - two-stage Barrett reduction of a full-width product
module mod_barrett_reduce
  import mod_mac_pkg::*;
#(
  parameter int MODULUS    = 177147,
  parameter int DATA_WIDTH = 18
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valid_i,
  input  logic [2*DATA_WIDTH-1:0] prod_i,
  output logic                    valid_o,
  output logic [DATA_WIDTH-1:0]   rem_o
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam logic [PW-1:0] FACT  = PW'(barrett_factor(MODULUS, DATA_WIDTH));
  localparam logic [PW-1:0] MOD_P = PW'(MODULUS);

  // Stage A: quotient estimate q = (p * m) >> 2W, never larger than the true quotient.
  logic [2*PW-1:0] qfull;
  logic [PW-1:0]   quo_d, quo_q;
  logic [PW-1:0]   prod_q;
  logic            va_q;

  assign qfull = {{PW{1'b0}}, prod_i} * {{PW{1'b0}}, FACT};
  assign quo_d = PW'(qfull >> PW);

  // Stage A register: quotient estimate plus the product it belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      va_q <= 1'b0;
    end else begin
      va_q <= valid_i;
    end
    prod_q <= prod_i;
    quo_q  <= quo_d;
  end

  // Stage B: the estimate undershoots by at most 2, so r < 3*MODULUS before correction.
  logic [PW-1:0]         qm;
  logic [PW-1:0]         r0, r1, r2;
  logic [DATA_WIDTH-1:0] rem_d, rem_q;
  logic                  vb_q;

  // Remainder with up to two conditional subtractions.
  always_comb begin
    qm    = quo_q * MOD_P;
    r0    = prod_q - qm;
    r1    = (r0 >= MOD_P) ? (r0 - MOD_P) : r0;
    r2    = (r1 >= MOD_P) ? (r1 - MOD_P) : r1;
    rem_d = DATA_WIDTH'(r2);
  end

  // Stage B register: reduced remainder.
  always_ff @(posedge clk) begin
    if (reset) begin
      vb_q <= 1'b0;
    end else begin
      vb_q <= va_q;
    end
    rem_q <= rem_d;
  end

  assign valid_o = vb_q;
  assign rem_o   = rem_q;

endmodule

// File: rtl/mod_mac_pipe.sv
// rtl/mod_mac_pipe.sv - pipelined (a*b + c [+ acc]) mod MODULUS, latency 4, 1 item/cycle
// Optional sticky operand range check: define MOD_MAC_RANGE_CHECK_EN.
module mod_mac_pipe
  import mod_mac_pkg::*;
#(
  parameter int MODULUS    = 177147,
  parameter int DATA_WIDTH = 18
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  input  logic [DATA_WIDTH-1:0] op_c,
  input  logic                  acc_en,
  input  logic                  acc_clr,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  range_err
);

  localparam int W  = DATA_WIDTH;
  localparam int PW = 2 * DATA_WIDTH;

  // Input capture stage.
  logic         in_v_q, in_en_q, in_clr_q;
  logic [W-1:0] in_a_q, in_b_q, in_c_q;

  // Register the accepted item; reset drops any item offered with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_v_q <= 1'b0;
    end else begin
      in_v_q <= in_valid;
    end
    in_a_q   <= op_a;
    in_b_q   <= op_b;
    in_c_q   <= op_c;
    in_en_q  <= acc_en;
    in_clr_q <= acc_clr;
  end

  // Multiply stage: full 2W-bit product, nothing truncated.
  logic          mul_v_q, mul_en_q, mul_clr_q;
  logic [PW-1:0] mul_p_d, mul_p_q;
  logic [W-1:0]  mul_c_q;

  assign mul_p_d = {{W{1'b0}}, in_a_q} * {{W{1'b0}}, in_b_q};

  // Register the product and carry the addend and accumulate flags along.
  always_ff @(posedge clk) begin
    if (reset) begin
      mul_v_q <= 1'b0;
    end else begin
      mul_v_q <= in_v_q;
    end
    mul_p_q   <= mul_p_d;
    mul_c_q   <= in_c_q;
    mul_en_q  <= in_en_q;
    mul_clr_q <= in_clr_q;
  end

  // Two reduction stages; the side registers below keep c and flags aligned.
  logic         red_v;
  logic [W-1:0] red_rem;

  mod_barrett_reduce #(
    .MODULUS   (MODULUS),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_reduce (
    .clk    (clk),
    .reset  (reset),
    .valid_i(mul_v_q),
    .prod_i (mul_p_q),
    .valid_o(red_v),
    .rem_o  (red_rem)
  );

  logic [W-1:0] r1_c_q, r2_c_q;
  logic         r1_en_q, r2_en_q, r1_clr_q, r2_clr_q;

  // Delay addend and flags by the reduction depth so they meet their remainder.
  always_ff @(posedge clk) begin
    r1_c_q   <= mul_c_q;
    r1_en_q  <= mul_en_q;
    r1_clr_q <= mul_clr_q;
    r2_c_q   <= r1_c_q;
    r2_en_q  <= r1_en_q;
    r2_clr_q <= r1_clr_q;
  end

  // Final stage: add c, then optionally the accumulator, each with one correction.
  // The accumulator is only read and written here, so consecutive items chain.
  localparam logic [W:0] MOD_X = (W + 1)'(MODULUS);

  logic         out_v_q;
  logic [W-1:0] result_d, result_q;
  logic [W-1:0] acc_d, acc_q;
  logic [W:0]   sum1, sum2;
  logic [W-1:0] part, addend, fin;

  // Next result and accumulator; both hold through bubbles.
  always_comb begin
    sum1     = {1'b0, red_rem} + {1'b0, r2_c_q};
    part     = (sum1 >= MOD_X) ? W'(sum1 - MOD_X) : W'(sum1);
    addend   = r2_clr_q ? '0 : acc_q;
    sum2     = {1'b0, part} + {1'b0, addend};
    fin      = (sum2 >= MOD_X) ? W'(sum2 - MOD_X) : W'(sum2);
    result_d = result_q;
    acc_d    = acc_q;
    if (red_v) begin
      if (r2_en_q) begin
        result_d = fin;
        acc_d    = fin;
      end else begin
        result_d = part;
        if (r2_clr_q) begin
          acc_d = '0;
        end
      end
    end
  end

  // Output and accumulator registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_v_q  <= 1'b0;
      result_q <= '0;
      acc_q    <= '0;
    end else begin
      out_v_q  <= red_v;
      result_q <= result_d;
      acc_q    <= acc_d;
    end
  end

  assign out_valid = out_v_q;
  assign result    = result_q;

`ifdef MOD_MAC_RANGE_CHECK_EN
  localparam logic [W-1:0] MOD_W = W'(MODULUS);
  logic range_err_q;

  // Sticky flag: any accepted operand at or above the modulus, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      range_err_q <= 1'b0;
    end else if (in_valid && ((op_a >= MOD_W) || (op_b >= MOD_W) || (op_c >= MOD_W))) begin
      range_err_q <= 1'b1;
    end
  end

  assign range_err = range_err_q;
`else
  assign range_err = 1'b0;
`endif

endmodule

// File: tb/tb_mod_mac_pipe.sv
// tb/tb_mod_mac_pipe.sv - directed self-checking bench for mod_mac_pipe
module tb_mod_mac_pipe;

  localparam int MODULUS = 177147;
  localparam int DW      = 18;
`ifdef MOD_MAC_RANGE_CHECK_EN
  localparam logic RANGE_EN = 1'b1;
`else
  localparam logic RANGE_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] op_a = '0, op_b = '0, op_c = '0;
  logic          acc_en = 1'b0, acc_clr = 1'b0;
  logic          out_valid;
  logic [DW-1:0] result;
  logic          range_err;

  int checks = 0;
  int errors = 0;

  mod_mac_pipe #(.MODULUS(MODULUS), .DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .op_a     (op_a),
    .op_b     (op_b),
    .op_c     (op_c),
    .acc_en   (acc_en),
    .acc_clr  (acc_clr),
    .out_valid(out_valid),
    .result   (result),
    .range_err(range_err)
  );

  always #5 clk = ~clk;

  // Present one item for one posedge; returns at the following negedge.
  task automatic drive(input int a, input int b, input int c, input logic en, input logic clr);
    in_valid = 1'b1;
    op_a = DW'(a); op_b = DW'(b); op_c = DW'(c);
    acc_en = en; acc_clr = clr;
    @(negedge clk);
    in_valid = 1'b0; acc_en = 1'b0; acc_clr = 1'b0;
  endtask

  task automatic wait_neg(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    wait_neg(3);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (result !== '0) begin errors++; $display("FAIL reset_result got %0d want 0", result); end
    checks++; if (range_err !== 1'b0) begin errors++; $display("FAIL reset_range_err got %b want 0", range_err); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_latency;
    drive(119687, 74565, 0, 1'b0, 1'b0);
    wait_neg(3);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_early got %b want 0", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL latency_valid got %b want 1", out_valid); end
    checks++; if (result !== 18'd149589) begin errors++; $display("FAIL latency_result got %0d want 149589", result); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bubble_valid got %b want 0", out_valid); end
    checks++; if (result !== 18'd149589) begin errors++; $display("FAIL bubble_hold got %0d want 149589", result); end
  endtask

  task automatic test_wrap;
    drive(177146, 177146, 0, 1'b0, 1'b0);
    drive(177146, 177146, 177146, 1'b0, 1'b0);
    drive(1000, 1000, 5, 1'b0, 1'b0);
    wait_neg(2);
    checks++; if (out_valid !== 1'b1 || result !== 18'd1) begin errors++; $display("FAIL wrap_sq got v=%b r=%0d want v=1 r=1", out_valid, result); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || result !== 18'd0) begin errors++; $display("FAIL wrap_sq_c got v=%b r=%0d want v=1 r=0", out_valid, result); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || result !== 18'd114270) begin errors++; $display("FAIL mid_value got v=%b r=%0d want v=1 r=114270", out_valid, result); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int exp_r [4];
    exp_r[0] = 1; exp_r[1] = 3; exp_r[2] = 6; exp_r[3] = 10;
    drive(1, 1, 0, 1'b1, 1'b1);
    drive(2, 1, 0, 1'b1, 1'b0);
    drive(3, 1, 0, 1'b1, 1'b0);
    drive(4, 1, 0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || result !== DW'(exp_r[i])) begin
        errors++; $display("FAIL chain_%0d got v=%b r=%0d want v=1 r=%0d", i, out_valid, result, exp_r[i]);
      end
    end
    // A non-accumulating item must leave the accumulator (10) alone.
    drive(2, 2, 0, 1'b0, 1'b0);
    drive(1, 1, 0, 1'b1, 1'b0);
    wait_neg(3);
    checks++; if (result !== 18'd4) begin errors++; $display("FAIL noacc_result got %0d want 4", result); end
    @(negedge clk);
    checks++; if (result !== 18'd11) begin errors++; $display("FAIL acc_kept got %0d want 11", result); end
    @(negedge clk);
  endtask

  task automatic test_acc_wrap;
    drive(177146, 1, 0, 1'b1, 1'b1);
    drive(177146, 1, 0, 1'b1, 1'b0);
    wait_neg(3);
    checks++; if (result !== 18'd177146) begin errors++; $display("FAIL accwrap_first got %0d want 177146", result); end
    @(negedge clk);
    checks++; if (result !== 18'd177145) begin errors++; $display("FAIL accwrap_second got %0d want 177145", result); end
    // Clear without accumulate: result is plain MAC, accumulator becomes 0.
    drive(2, 3, 4, 1'b0, 1'b1);
    drive(1, 1, 0, 1'b1, 1'b0);
    wait_neg(3);
    checks++; if (result !== 18'd10) begin errors++; $display("FAIL clr_noen_result got %0d want 10", result); end
    @(negedge clk);
    checks++; if (result !== 18'd1) begin errors++; $display("FAIL clr_noen_acc got %0d want 1", result); end
    @(negedge clk);
  endtask

  task automatic test_reset_flight;
    int seen;
    drive(7, 7, 0, 1'b1, 1'b0);
    drive(8, 8, 0, 1'b1, 1'b0);
    drive(9, 9, 0, 1'b1, 1'b0);
    seen = 0;
    @(negedge clk);
    if (out_valid === 1'b1) seen++;
    reset = 1'b1;
    in_valid = 1'b1; op_a = 18'd9; op_b = 18'd9; op_c = '0; acc_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    reset = 1'b0; in_valid = 1'b0; acc_en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL flight_discard got %0d valid cycles want 0", seen); end
    checks++; if (result !== '0) begin errors++; $display("FAIL flight_result got %0d want 0", result); end
    drive(5, 7, 0, 1'b0, 1'b0);
    drive(1, 1, 0, 1'b1, 1'b0);
    wait_neg(3);
    checks++; if (out_valid !== 1'b1 || result !== 18'd35) begin errors++; $display("FAIL post_reset got v=%b r=%0d want v=1 r=35", out_valid, result); end
    @(negedge clk);
    checks++; if (result !== 18'd1) begin errors++; $display("FAIL post_reset_acc got %0d want 1", result); end
    @(negedge clk);
  endtask

  task automatic test_range;
    drive(177147, 1, 0, 1'b0, 1'b0);
    wait_neg(2);
    checks++; if (range_err !== RANGE_EN) begin errors++; $display("FAIL range_set got %b want %b", range_err, RANGE_EN); end
    drive(3, 4, 0, 1'b0, 1'b0);
    wait_neg(5);
    checks++; if (result !== 18'd12) begin errors++; $display("FAIL range_legal got %0d want 12", result); end
    checks++; if (range_err !== RANGE_EN) begin errors++; $display("FAIL range_sticky got %b want %b", range_err, RANGE_EN); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (range_err !== 1'b0) begin errors++; $display("FAIL range_reset got %b want 0", range_err); end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_latency();
    test_wrap();
    test_back_to_back();
    test_acc_wrap();
    test_reset_flight();
    test_range();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
